// File: rtl/hls_core_run_ctrl.sv
// Run controller for one HLS core: sequences ap_start/ap_ready/ap_done for N invocations,
// holds completion until snooped AXI traffic retires, and reports elapsed cycles and status.
module hls_core_run_ctrl #(
  parameter int CYCLE_W        = 32,
  parameter int ITER_W         = 16,
  parameter int OUTST_W        = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ITER_W-1:0]  cmd_iters,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [CYCLE_W-1:0] rsp_cycles,
  output logic [1:0]         rsp_status,
  output logic               core_ap_start,
  input  logic               core_ap_ready,
  input  logic               core_ap_done,
  output logic               core_rst_n,
  input  logic               mon_awvalid,
  input  logic               mon_awready,
  input  logic               mon_arvalid,
  input  logic               mon_arready,
  input  logic               mon_rvalid,
  input  logic               mon_rready,
  input  logic               mon_rlast,
  input  logic               mon_bvalid,
  input  logic               mon_bready,
  input  logic [1:0]         mon_rresp,
  input  logic [1:0]         mon_bresp
);

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, RESP, RECOVER} state_t;

  localparam logic [1:0]         ST_OK       = 2'b00;
  localparam logic [1:0]         ST_TIMEOUT  = 2'b01;
  localparam logic [1:0]         ST_BUS_ERR  = 2'b10;
  localparam logic [CYCLE_W-1:0] TIMEOUT_LIM = CYCLE_W'(TIMEOUT_CYCLES);

  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

  // Saturating up/down counter; a simultaneous issue and retire cancel out.
  function automatic logic [OUTST_W-1:0] outst_next(input logic [OUTST_W-1:0] cnt,
                                                     input logic inc, input logic dec);
    logic [OUTST_W-1:0] res;
    res = cnt;
    if (inc && !dec && !(&cnt))
      res = cnt + 1'b1;
    else if (dec && !inc && (cnt != '0))
      res = cnt - 1'b1;
    return res;
  endfunction

  state_t             state;
  logic [ITER_W-1:0]  remaining;
  logic [CYCLE_W-1:0] cycles;
  logic [CYCLE_W-1:0] cycles_inc;
  logic [OUTST_W-1:0] wr_outst;
  logic [OUTST_W-1:0] rd_outst;
  logic [1:0]         rec_cnt;
  logic [1:0]         status_q;
  logic               err;
  logic               rsp_valid_q;
  logic               ap_start_q;
  logic               aw_hs, ar_hs, b_hs, r_hs, rlast_hs;
  logic               err_evt, timeout_hit, last_iter, drained;
  logic               unused_resp_lsbs;

  assign aw_hs            = mon_awvalid && mon_awready;
  assign ar_hs            = mon_arvalid && mon_arready;
  assign b_hs             = mon_bvalid && mon_bready;
  assign r_hs             = mon_rvalid && mon_rready;
  assign rlast_hs         = r_hs && mon_rlast;
  assign err_evt          = (b_hs && mon_bresp[1]) || (r_hs && mon_rresp[1]);
  assign unused_resp_lsbs = mon_bresp[0] ^ mon_rresp[0];
  assign cycles_inc       = sat_inc(cycles);
  // The watchdog fires on the edge where the counter reaches the limit.
  assign timeout_hit      = (TIMEOUT_CYCLES != 0) && (cycles_inc == TIMEOUT_LIM);
  assign last_iter        = (remaining == ITER_W'(1));
  assign drained          = (wr_outst == '0) && (rd_outst == '0);

  assign cmd_ready     = ap_rst_n && (state == IDLE);
  assign rsp_valid     = ap_rst_n && rsp_valid_q;
  assign core_ap_start = ap_rst_n && ap_start_q;
  assign core_rst_n    = ap_rst_n && (state != RECOVER);
  assign rsp_cycles    = cycles;
  assign rsp_status    = status_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      cycles      <= '0;
      wr_outst    <= '0;
      rd_outst    <= '0;
      rec_cnt     <= '0;
      status_q    <= ST_OK;
      err         <= 1'b0;
      rsp_valid_q <= 1'b0;
      ap_start_q  <= 1'b0;
    end else begin
      wr_outst <= (state == RECOVER) ? '0 : outst_next(wr_outst, aw_hs, b_hs);
      rd_outst <= (state == RECOVER) ? '0 : outst_next(rd_outst, ar_hs, rlast_hs);
      if (state != IDLE && err_evt)
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            remaining  <= (cmd_iters == '0) ? ITER_W'(1) : cmd_iters;
            cycles     <= '0;
            err        <= 1'b0;
            ap_start_q <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          cycles <= cycles_inc;
          if (timeout_hit) begin
            ap_start_q <= 1'b0;
            rec_cnt    <= '0;
            state      <= RECOVER;
          end else if (core_ap_ready) begin
            if (!core_ap_done) begin
              ap_start_q <= 1'b0;
              state      <= RUN;
            end else if (last_iter) begin
              ap_start_q <= 1'b0;
              state      <= DRAIN;
            end else begin
              remaining  <= remaining - 1'b1;
              ap_start_q <= 1'b1;
              state      <= START;
            end
          end
        end
        RUN: begin
          cycles <= cycles_inc;
          if (timeout_hit) begin
            rec_cnt <= '0;
            state   <= RECOVER;
          end else if (core_ap_done) begin
            if (last_iter) begin
              state <= DRAIN;
            end else begin
              remaining  <= remaining - 1'b1;
              ap_start_q <= 1'b1;
              state      <= START;
            end
          end
        end
        DRAIN: begin
          cycles <= cycles_inc;
          if (timeout_hit) begin
            rec_cnt <= '0;
            state   <= RECOVER;
          end else if (drained) begin
            rsp_valid_q <= 1'b1;
            status_q    <= (err || err_evt) ? ST_BUS_ERR : ST_OK;
            state       <= RESP;
          end
        end
        RECOVER: begin
          cycles <= cycles_inc;
          if (rec_cnt == 2'd3) begin
            rsp_valid_q <= 1'b1;
            status_q    <= ST_TIMEOUT;
            state       <= RESP;
          end else begin
            rec_cnt <= rec_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_core_run_ctrl.sv
// Bench for hls_core_run_ctrl: scripted and randomized core/AXI behaviour, with expected
// elapsed cycles, status and start count derived from the scenario description.
`timescale 1ns/1ps
module tb_hls_core_run_ctrl;
  localparam int CYCLE_W = 32;
  localparam int ITER_W  = 16;
  localparam int OUTST_W = 8;
  localparam int TO_LIM  = 50;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [ITER_W-1:0]  cmd_iters = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [CYCLE_W-1:0] rsp_cycles;
  logic [1:0]         rsp_status;
  logic               core_ap_start;
  logic               core_ap_ready = 1'b0;
  logic               core_ap_done = 1'b0;
  logic               core_rst_n;
  logic               mon_awvalid = 1'b0, mon_awready = 1'b0;
  logic               mon_arvalid = 1'b0, mon_arready = 1'b0;
  logic               mon_rvalid = 1'b0, mon_rready = 1'b0, mon_rlast = 1'b0;
  logic               mon_bvalid = 1'b0, mon_bready = 1'b0;
  logic [1:0]         mon_rresp = 2'b00, mon_bresp = 2'b00;

  always #5 ap_clk = ~ap_clk;

  hls_core_run_ctrl #(
    .CYCLE_W(CYCLE_W), .ITER_W(ITER_W), .OUTST_W(OUTST_W), .TIMEOUT_CYCLES(TO_LIM)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_iters(cmd_iters),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cycles(rsp_cycles), .rsp_status(rsp_status),
    .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready), .core_ap_done(core_ap_done),
    .core_rst_n(core_rst_n),
    .mon_awvalid(mon_awvalid), .mon_awready(mon_awready),
    .mon_arvalid(mon_arvalid), .mon_arready(mon_arready),
    .mon_rvalid(mon_rvalid), .mon_rready(mon_rready), .mon_rlast(mon_rlast),
    .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
    .mon_rresp(mon_rresp), .mon_bresp(mon_bresp)
  );

  int checks = 0;
  int errors = 0;
  int start_hs = 0;

  always @(posedge ap_clk)
    if (ap_rst_n && core_ap_start && core_ap_ready) start_hs++;

  // Scenario description consumed by run_cmd.
  int sc_rd[4];
  int sc_dd[4];
  bit sc_traffic;
  int sc_k;
  bit sc_bad_b;
  bit sc_bad_r;
  int sc_hold;
  bit sc_noise;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_awvalid = 0; mon_awready = 0; mon_arvalid = 0; mon_arready = 0;
    mon_rvalid = 0; mon_rready = 0; mon_rlast = 0; mon_rresp = 2'b00;
    mon_bvalid = 0; mon_bready = 0; mon_bresp = 2'b00;
  endtask

  task automatic set_plain();
    for (int i = 0; i < 4; i++) begin sc_rd[i] = 0; sc_dd[i] = 0; end
    sc_traffic = 0; sc_k = 4; sc_bad_b = 0; sc_bad_r = 0; sc_hold = 0; sc_noise = 0;
  endtask

  task automatic run_cmd(input string tag, input logic [ITER_W-1:0] iters_field);
    int n, exp_cyc, exp_st, hs0;
    n = (iters_field == 0) ? 1 : int'(iters_field);
    exp_cyc = 0;
    for (int i = 0; i < n; i++) exp_cyc += sc_rd[i] + 1 + sc_dd[i];
    exp_cyc += sc_traffic ? sc_k + 1 : 1;
    exp_st = (sc_traffic && (sc_bad_b || sc_bad_r)) ? 2 : 0;

    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready_idle: got %b want 1", tag, cmd_ready); end
    hs0 = start_hs;
    cmd_valid = 1; cmd_iters = iters_field;
    tick();
    cmd_valid = 0; cmd_iters = ITER_W'($urandom);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL %s cmd_ready_busy: got %b want 0", tag, cmd_ready); end

    for (int i = 0; i < n; i++) begin
      checks++;
      if (core_ap_start !== 1'b1) begin errors++; $display("FAIL %s ap_start_high[%0d]: got %b want 1", tag, i, core_ap_start); end
      for (int j = 0; j < sc_rd[i]; j++) begin
        if (sc_traffic && i == 0) begin
          mon_awvalid = (j < 2); mon_awready = (j < 2);
          mon_arvalid = (j == 0); mon_arready = (j == 0);
        end
        if (sc_noise) cmd_valid = 1'($urandom);
        tick();
        clear_mon();
      end
      core_ap_ready = 1; core_ap_done = (sc_dd[i] == 0);
      tick();
      core_ap_ready = 0; core_ap_done = 0;
      if (sc_dd[i] > 0) begin
        checks++;
        if (core_ap_start !== 1'b0) begin errors++; $display("FAIL %s ap_start_low[%0d]: got %b want 0", tag, i, core_ap_start); end
        for (int j = 0; j < sc_dd[i] - 1; j++) begin
          if (sc_noise) begin cmd_valid = 1'($urandom); core_ap_ready = 1'($urandom); end
          tick();
          core_ap_ready = 0;
        end
        core_ap_done = 1;
        tick();
        core_ap_done = 0;
      end
    end
    cmd_valid = 0;

    if (sc_traffic) begin
      for (int d = 1; d <= sc_k; d++) begin
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s drain_hold[%0d]: got %b want 0", tag, d, rsp_valid); end
        if (d == 1 || d == sc_k) begin
          mon_bvalid = 1; mon_bready = 1; mon_bresp = (d == 1 && sc_bad_b) ? 2'b10 : 2'b00;
        end else if (d == 2) begin
          mon_bvalid = 1; mon_bready = 0; mon_bresp = 2'b10;
        end
        if (d <= 3) begin
          mon_rvalid = 1; mon_rready = 1; mon_rlast = 0; mon_rresp = (d == 2 && sc_bad_r) ? 2'b10 : 2'b00;
        end else if (d == sc_k) begin
          mon_rvalid = 1; mon_rready = 1; mon_rlast = 1; mon_rresp = 2'b00;
        end else begin
          mon_rvalid = 1; mon_rready = 0; mon_rlast = 1; mon_rresp = 2'b10;
        end
        tick();
        clear_mon();
      end
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s drain_last: got %b want 0", tag, rsp_valid); end
    tick();

    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s rsp_valid: got %b want 1", tag, rsp_valid); end
    checks++;
    if (rsp_cycles !== CYCLE_W'(exp_cyc)) begin errors++; $display("FAIL %s rsp_cycles: got %0d want %0d", tag, rsp_cycles, exp_cyc); end
    checks++;
    if (rsp_status !== 2'(exp_st)) begin errors++; $display("FAIL %s rsp_status: got %b want %b", tag, rsp_status, 2'(exp_st)); end
    checks++;
    if (start_hs - hs0 !== n) begin errors++; $display("FAIL %s start_count: got %0d want %0d", tag, start_hs - hs0, n); end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL %s cmd_ready_resp: got %b want 0", tag, cmd_ready); end

    for (int h = 0; h < sc_hold; h++) begin
      cmd_valid = 1; rsp_ready = 0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_cycles !== CYCLE_W'(exp_cyc) || rsp_status !== 2'(exp_st) || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[%0d]: got v=%b cyc=%0d st=%b rdy=%b want v=1 cyc=%0d st=%b rdy=0",
                 tag, h, rsp_valid, rsp_cycles, rsp_status, cmd_ready, exp_cyc, 2'(exp_st));
      end
    end
    cmd_valid = 0; rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s rsp_release: got v=%b rdy=%b want v=0 rdy=1", tag, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 0;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, rsp_valid, core_ap_start, core_rst_n} !== 4'b0000 || rsp_cycles !== '0 || rsp_status !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b v=%b st=%b crst=%b cyc=%0d sts=%b want all 0",
               cmd_ready, rsp_valid, core_ap_start, core_rst_n, rsp_cycles, rsp_status);
    end
    ap_rst_n = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || core_rst_n !== 1'b1) begin
      errors++; $display("FAIL reset_release: got rdy=%b crst=%b want 1 1", cmd_ready, core_rst_n);
    end
  endtask

  task automatic test_single();
    set_plain(); sc_dd[0] = 8;
    run_cmd("single", 16'd1);
  endtask

  task automatic test_back_to_back();
    set_plain();
    run_cmd("b2b", 16'd3);
  endtask

  task automatic test_axi_drain();
    set_plain(); sc_rd[0] = 2; sc_dd[0] = 3; sc_traffic = 1; sc_k = 5;
    run_cmd("axi_drain", 16'd1);
  endtask

  task automatic test_bus_err();
    set_plain(); sc_rd[0] = 2; sc_dd[0] = 1; sc_traffic = 1; sc_k = 4; sc_bad_b = 1;
    run_cmd("bus_err", 16'd1);
  endtask

  task automatic test_zero_iters();
    set_plain(); sc_dd[0] = 2; sc_hold = 5;
    run_cmd("zero_iters", 16'd0);
  endtask

  task automatic test_timeout(input bit done_at_limit);
    string tag;
    tag = done_at_limit ? "timeout_vs_done" : "timeout";
    cmd_valid = 1; cmd_iters = 16'd1;
    tick();
    cmd_valid = 0;
    for (int c = 1; c <= 54; c++) begin
      if (c == 1) begin core_ap_ready = 1; mon_awvalid = 1; mon_awready = 1; end
      if (done_at_limit && c == TO_LIM) core_ap_done = 1;
      tick();
      core_ap_ready = 0; core_ap_done = 0; clear_mon();
      checks++;
      if (core_rst_n !== !(c >= TO_LIM && c <= TO_LIM + 3)) begin
        errors++; $display("FAIL %s core_rst_n[%0d]: got %b want %b", tag, c, core_rst_n, !(c >= TO_LIM && c <= TO_LIM + 3));
      end
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_cycles !== CYCLE_W'(54) || rsp_status !== 2'b01) begin
      errors++; $display("FAIL %s rsp: got v=%b cyc=%0d st=%b want v=1 cyc=54 st=01", tag, rsp_valid, rsp_cycles, rsp_status);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s back_idle: got %b want 1", tag, cmd_ready); end
  endtask

  task automatic test_mid_reset();
    cmd_valid = 1; cmd_iters = 16'd2;
    tick();
    cmd_valid = 0; core_ap_ready = 1; mon_awvalid = 1; mon_awready = 1;
    tick();
    core_ap_ready = 0; clear_mon();
    tick();
    ap_rst_n = 0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || core_rst_n !== 1'b0) begin
      errors++; $display("FAIL mid_reset_low: got rdy=%b crst=%b want 0 0", cmd_ready, core_rst_n);
    end
    tick();
    ap_rst_n = 1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || core_ap_start !== 1'b0 || rsp_cycles !== '0 || rsp_status !== 2'b00 || core_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_idle: got rdy=%b st=%b cyc=%0d sts=%b crst=%b want 1 0 0 00 1",
               cmd_ready, core_ap_start, rsp_cycles, rsp_status, core_rst_n);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_rsp[%0d]: got %b want 0", i, rsp_valid); end
    end
    set_plain(); sc_dd[0] = 1;
    run_cmd("post_reset", 16'd1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 24; r++) begin
      int n;
      logic [ITER_W-1:0] field;
      set_plain();
      n = $urandom_range(1, 3);
      field = (n == 1 && $urandom_range(0, 3) == 0) ? 16'd0 : ITER_W'(n);
      for (int i = 0; i < n; i++) begin
        sc_rd[i] = $urandom_range(0, 3);
        sc_dd[i] = $urandom_range(0, 5);
      end
      sc_traffic = 1'($urandom);
      if (sc_traffic && sc_rd[0] < 2) sc_rd[0] = 2;
      sc_k = $urandom_range(4, 7);
      sc_bad_b = sc_traffic && ($urandom_range(0, 2) == 0);
      sc_bad_r = sc_traffic && ($urandom_range(0, 2) == 0);
      sc_hold = $urandom_range(0, 3);
      sc_noise = 1;
      run_cmd($sformatf("rand%0d", r), field);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_axi_drain();
    test_bus_err();
    test_zero_iters();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
